piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the serial ones-count-mod-4 detector; its `dout` drives that detector's `din`.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Drives `dout`=0 whenever idle, so idle cycles never disturb the downstream ones count.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word; sampled only on an accepted load.
- load_valid  input  1  upstream asserts when data_in holds a word.
- load_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit; 0 when not shifting.
- dout_valid  output  1  high on every cycle `dout` carries a frame bit.
- busy  output  1  high while a frame is in progress (state != IDLE).
- frame_done  output  1  single-cycle pulse, coincident with the last bit of a frame.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, shift register=0, bit counter=0.
  - Outputs: dout=0, dout_valid=0, busy=0, frame_done=0, load_ready=1.
- Load acceptance:
  - A load is accepted on a rising edge where load_valid && load_ready.
  - data_in is captured into the shift register; bit counter clears to 0.
  - The first bit appears on the cycle after acceptance (latency 1).
  - load_valid while load_ready=0 is ignored; upstream must hold data_in and load_valid.
- States:
  - IDLE:
    - load_ready=1; dout=0; dout_valid=0.
    - On accept -> SHIFT.
  - SHIFT:
    - dout=shift_reg[WIDTH-1]; dout_valid=1.
    - Each clock: shift left by 1 (LSB filled with 0), counter+1.
    - When counter==WIDTH-1 (last bit): frame_done=1 and load_ready=1.
    - On that edge: if a load is accepted -> SHIFT with the new word (gapless, no idle bubble); otherwise -> IDLE.
    - Before the last bit, load_ready=0.
  - PAR (only with SER_PARITY_EN): see Optional Feature.
- Output derivation:
  - load_ready, dout, dout_valid, busy and frame_done are decoded from registered state only.
  - No combinational path from any input to any output.
- Counter width: $clog2(WIDTH); wrap from WIDTH-1 is never reached, because the counter reloads to 0 on accept or holds in IDLE.
- Reset mid-frame: frame is aborted immediately; dout goes to 0 asynchronously; no frame_done pulse.
- Back-to-back words produce a continuous bit stream of exactly WIDTH bits per word.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After the last data bit, SHIFT -> PAR for one cycle.
  - In PAR: dout = XOR of the captured word (even parity), dout_valid=1.
  - frame_done and load_ready move from the last data cycle to the PAR cycle; in the last data cycle both are 0.
  - Frame length is WIDTH+1 cycles.
  - Every frame then carries an even number of ones.
- Undefined:
  - No PAR state; frame length is WIDTH cycles; behaviour as above.

Test Plan:
- Reset then load 8'hB4 -> dout sequence 1,0,1,1,0,1,0,0 on cycles 1..8 after accept; dout_valid=1 on exactly those 8 cycles; frame_done only on cycle 8; downstream detector sees 4 ones and returns to count 0.
- load_valid held high with words 8'hFF then 8'h01 -> 16 consecutive valid bits, no gap; load_ready high only on cycle 8 (and in IDLE); frame_done pulses on cycles 8 and 16.
- load_valid asserted on cycle 3 of a frame -> ignored; word accepted only when load_ready=1 on cycle 8.
- Assert reset on cycle 4 of a frame of 8'hF0 -> dout=0, busy=0, load_ready=1 immediately; no frame_done; the next load starts a clean frame.
- Idle for 20 cycles with load_valid=0 -> dout=0, dout_valid=0 throughout.
- With SER_PARITY_EN defined, load 8'h07 -> bits 0,0,0,0,0,1,1,1 then parity 1 on cycle 9; frame_done and load_ready on cycle 9 only.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
// master = word producer / observer side, slave = the serializer itself.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    // Load handshake: a word moves on a rising edge where load_valid && load_ready.
    // The producer holds data_in and load_valid stable until that edge, and
    // load_ready never depends on load_valid within the same cycle.
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             frame_done;
    logic [1:0]       dbg_state;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        input  dout,
        input  dout_valid,
        input  busy,
        input  frame_done,
        input  dbg_state
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        output dout,
        output dout_valid,
        output busy,
        output frame_done,
        output dbg_state
    );
endinterface

// File: rtl/piso_serializer.sv
// MSB-first parallel-to-serial shifter; dout idles at 0 so a downstream ones counter is undisturbed.
// Optional trailing even-parity bit is enabled by defining SER_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    piso_serializer_if.slave     bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             load_ready_q, load_ready_d;
    logic             accept;

    // Ready comes from a flop, so acceptance never forms an input-to-output path.
    assign accept = bus.load_valid && load_ready_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef SER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shift_d = bus.data_in;
                    cnt_d   = '0;
`ifdef SER_PARITY_EN
                    par_d   = ^bus.data_in;
`endif
                end
            end
            SHIFT: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                if (cnt_q == LAST) begin
`ifdef SER_PARITY_EN
                    state_d = PAR;
`else
                    if (accept) begin
                        state_d = SHIFT;
                        shift_d = bus.data_in;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef SER_PARITY_EN
            PAR: begin
                if (accept) begin
                    state_d = SHIFT;
                    shift_d = bus.data_in;
                    cnt_d   = '0;
                    par_d   = ^bus.data_in;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are precomputed from next state so they leave straight from flops.
    always_comb begin
        dout_d       = 1'b0;
        dout_valid_d = (state_d != IDLE);
        busy_d       = (state_d != IDLE);
        frame_done_d = 1'b0;
        if (state_d == SHIFT) begin
            dout_d = shift_d[WIDTH-1];
        end
`ifdef SER_PARITY_EN
        if (state_d == PAR) begin
            dout_d       = par_d;
            frame_done_d = 1'b1;
        end
`else
        if ((state_d == SHIFT) && (cnt_d == LAST)) begin
            frame_done_d = 1'b1;
        end
`endif
        load_ready_d = (state_d == IDLE) || frame_done_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
`ifdef SER_PARITY_EN
            par_q        <= 1'b0;
`endif
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
`ifdef SER_PARITY_EN
            par_q        <= par_d;
`endif
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.load_ready = load_ready_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: cycle model plus bit-stream scoreboard.
// Covers reset, single and back-to-back frames, ignored loads, mid-frame reset, idle and random traffic.
module tb_piso_serializer;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FLEN = W + (PAR_EN ? 1 : 0);

  logic clk;
  logic reset;

  piso_serializer_if #(.WIDTH(W)) bus ();

  piso_serializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model / scoreboard ----------------
  logic [1:0] exp_q[$];   // {expected dout, expected frame_done}
  int         m_left;     // frame cycles still to show, including the current one
  logic       m_accept;
  int         n_tests;
  int         n_fail;

  // Advance one clock: model the accept edge, then check every output at the falling edge.
  task automatic tick();
    logic [1:0] e;
    logic [4:0] obs;
    logic [4:0] exp_v;
    @(posedge clk);
    m_accept = bus.load_valid && (m_left <= 1);
    if (m_accept) begin
      for (int i = W - 1; i >= 0; i--) begin
        exp_q.push_back({bus.data_in[i], (i == 0) && !PAR_EN});
      end
      if (PAR_EN) exp_q.push_back({^bus.data_in, 1'b1});
      m_left = FLEN;
    end else if (m_left > 0) begin
      m_left--;
    end
    @(negedge clk);
    e = 2'b00;
    if (m_left > 0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_underflow: queue empty while a frame bit is due");
      end else begin
        e = exp_q.pop_front();
      end
    end
    obs   = {bus.dout, bus.dout_valid, bus.frame_done, bus.load_ready, bus.busy};
    exp_v = {e[1], m_left > 0, e[0], m_left <= 1, m_left > 0};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_outputs {dout,valid,done,ready,busy}: got %b expected %b (t=%0t)",
               obs, exp_v, $time);
    end
  endtask

  task automatic model_clear();
    m_left = 0;
    exp_q.delete();
  endtask

  // Driver: present one word until accepted, then drop load_valid.
  task automatic send_word(input logic [W-1:0] w);
    int guard;
    bus.data_in    = w;
    bus.load_valid = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!m_accept && guard < 3 * FLEN);
    if (!m_accept) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: word %h not accepted within %0d cycles", w, guard);
    end
    bus.load_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [5:0] obs;
    reset          = 1'b1;
    bus.load_valid = 1'b0;
    bus.data_in    = '0;
    model_clear();
    repeat (2) @(negedge clk);
    obs = {bus.dout, bus.dout_valid, bus.busy, bus.frame_done, bus.load_ready, bus.dbg_state == 2'd0};
    n_tests++;
    if (obs !== 6'b000011) begin
      n_fail++;
      $display("FAIL reset_outputs {dout,valid,busy,done,ready,idle}: got %b expected 000011", obs);
    end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single_b4();
    logic [W-1:0] pat;
    int ones, nvalid, ndone, done_at;
    pat = 8'hB4;
    ones = 0; nvalid = 0; ndone = 0; done_at = -1;
    bus.data_in    = pat;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    for (int c = 1; c <= FLEN + 3; c++) begin
      if (c > 1) tick();
      if (c <= W) begin
        n_tests++;
        if (bus.dout !== pat[W-c]) begin
          n_fail++;
          $display("FAIL b4_bit%0d: got %b expected %b", c, bus.dout, pat[W-c]);
        end
      end
      if (bus.dout_valid) nvalid++;
      if (bus.dout) ones++;
      if (bus.frame_done) begin ndone++; done_at = c; end
    end
    n_tests++;
    if (nvalid !== FLEN) begin
      n_fail++;
      $display("FAIL b4_valid_count: got %0d expected %0d", nvalid, FLEN);
    end
    n_tests++;
    if (ndone !== 1 || done_at !== FLEN) begin
      n_fail++;
      $display("FAIL b4_frame_done: got %0d pulses at cycle %0d expected 1 at %0d", ndone, done_at, FLEN);
    end
    n_tests++;
    if (ones !== 4) begin
      n_fail++;
      $display("FAIL b4_ones: got %0d expected 4", ones);
    end
  endtask

  task automatic test_back_to_back();
    int nacc, gaps;
    nacc = 0; gaps = 0;
    bus.data_in    = 8'hFF;
    bus.load_valid = 1'b1;
    for (int c = 1; c <= 2 * FLEN + 2; c++) begin
      tick();
      if (m_accept) begin
        nacc++;
        if (nacc == 1) bus.data_in = 8'h01;
        if (nacc == 2) bus.load_valid = 1'b0;
      end
      if (c <= 2 * FLEN) begin
        if (!bus.dout_valid) gaps++;
        n_tests++;
        if (bus.frame_done !== ((c == FLEN) || (c == 2 * FLEN))) begin
          n_fail++;
          $display("FAIL b2b_done_c%0d: got %b", c, bus.frame_done);
        end
        n_tests++;
        if (bus.load_ready !== ((c == FLEN) || (c == 2 * FLEN))) begin
          n_fail++;
          $display("FAIL b2b_ready_c%0d: got %b", c, bus.load_ready);
        end
      end
    end
    n_tests++;
    if (gaps !== 0) begin
      n_fail++;
      $display("FAIL b2b_gapless: got %0d idle cycles expected 0", gaps);
    end
  endtask

  task automatic test_ignored_load();
    bus.data_in    = 8'hA5;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    for (int c = 2; c <= FLEN; c++) begin
      tick();
      if (c == 3) begin
        bus.data_in    = 8'h3C;
        bus.load_valid = 1'b1;
      end
      n_tests++;
      if (bus.load_ready !== (c == FLEN)) begin
        n_fail++;
        $display("FAIL ignored_ready_c%0d: got %b expected %b", c, bus.load_ready, c == FLEN);
      end
    end
    tick();
    bus.load_valid = 1'b0;
    n_tests++;
    if (m_accept !== 1'b1 || bus.dout !== 1'b0 || bus.dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ignored_late_accept: accept %b dout %b valid %b expected 1 0 1",
               m_accept, bus.dout, bus.dout_valid);
    end
    repeat (FLEN + 1) tick();
  endtask

  task automatic test_reset_abort();
    logic [4:0] obs;
    bus.data_in    = 8'hF0;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    obs = {bus.dout, bus.dout_valid, bus.busy, bus.frame_done, bus.load_ready};
    n_tests++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL abort_outputs {dout,valid,busy,done,ready}: got %b expected 00001", obs);
    end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    send_word(8'h5A);
    repeat (FLEN + 1) tick();
  endtask

  task automatic test_idle();
    bus.load_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_tests++;
      if (bus.dout !== 1'b0 || bus.dout_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_c%0d: dout %b valid %b expected 0 0", c, bus.dout, bus.dout_valid);
      end
    end
  endtask

  task automatic test_word_07();
    int ones, done_at;
    ones = 0; done_at = -1;
    bus.data_in    = 8'h07;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    for (int c = 1; c <= FLEN + 1; c++) begin
      if (c > 1) tick();
      if (bus.dout) ones++;
      if (bus.frame_done) done_at = c;
      if (c <= FLEN) begin
        n_tests++;
        if (bus.load_ready !== (c == FLEN)) begin
          n_fail++;
          $display("FAIL w07_ready_c%0d: got %b", c, bus.load_ready);
        end
      end
    end
    n_tests++;
    if (ones !== (PAR_EN ? 4 : 3) || done_at !== FLEN) begin
      n_fail++;
      $display("FAIL w07_frame: ones %0d done at %0d expected %0d at %0d",
               ones, done_at, PAR_EN ? 4 : 3, FLEN);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      send_word(W'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (FLEN + 2) tick();
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL random_drain: %0d bits left in scoreboard expected 0", exp_q.size());
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_left  = 0;
    m_accept = 1'b0;
    test_reset();
    test_single_b4();
    test_back_to_back();
    test_ignored_load();
    test_reset_abort();
    test_idle();
    test_word_07();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
